if_stage: RTL and testbench

Parametrised instruction-fetch stage for the pipelined MIPS32 core. It owns the program counter, drives the instruction-ROM address, and registers the IF/ID pipeline latch. It arbitrates the next PC among sequential fetch, stall, branch/jump redirect, interrupt entry and exception entry, and captures the return address (EPC) for `$26` write-back. It sits between the instruction ROM and the decode/control stage.

---
 rtl/if_stage.sv | 109 ++++++++++
 tb/tb_if_stage.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// MIPS32 instruction-fetch stage: owns the PC, drives the ROM address, registers IF/ID,
// and picks the next PC from exception, interrupt, redirect, stall and sequential fetch.
module if_stage #(
    parameter int unsigned   AW        = 32,
    parameter int unsigned   IW        = 32,
    parameter logic [AW-1:0] RESET_VEC = AW'(0),
    parameter logic [AW-1:0] IRQ_VEC   = AW'(32'h8000_0004),
    parameter logic [AW-1:0] EXC_VEC   = AW'(32'h8000_0008),
    parameter int unsigned   CNTW      = 16
) (
    input  logic            clk,
    input  logic            reset,
    output logic [AW-1:0]   imem_addr,
    input  logic [IW-1:0]   imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [AW-1:0]   redirect_pc,
    input  logic            irq,
    input  logic            exc,
    input  logic [AW-1:0]   exc_pc,
    output logic [AW-1:0]   pc,
    output logic            id_valid,
    output logic [IW-1:0]   id_instr,
    output logic [AW-1:0]   id_pc,
    output logic [AW-1:0]   id_pcp4,
    output logic [AW-1:0]   epc,
    output logic            irq_take,
    output logic [CNTW-1:0] fetch_cnt
);

    logic [AW-1:0]   pc_plus4;
    logic [AW-1:0]   pc_target;
    logic [AW-1:0]   pc_nxt;
    logic            irq_acc;
    logic            id_valid_nxt;
    logic [IW-1:0]   id_instr_nxt;
    logic [AW-1:0]   id_pc_nxt;
    logic [AW-1:0]   id_pcp4_nxt;
    logic [AW-1:0]   epc_nxt;
    logic [CNTW-1:0] fetch_cnt_nxt;

    // ROM is addressed with the kernel bit stripped
    assign imem_addr = {1'b0, pc[AW-2:0]};

    // Next-state selection, highest priority first
    always_comb begin
        pc_plus4      = pc + AW'(4);
        irq_acc       = irq & ~pc[AW-1] & ~stall & ~exc;
        pc_target     = pc;
        id_valid_nxt  = id_valid;
        id_instr_nxt  = id_instr;
        id_pc_nxt     = id_pc;
        id_pcp4_nxt   = id_pcp4;
        epc_nxt       = epc;
        fetch_cnt_nxt = fetch_cnt;

        if (exc) begin
            pc_target = EXC_VEC;
            epc_nxt   = exc_pc;
        end else if (irq_acc) begin
            pc_target = IRQ_VEC;
            epc_nxt   = redirect ? redirect_pc : pc;
        end else if (redirect) begin
            pc_target = redirect_pc;
        end else if (!stall) begin
            pc_target     = pc_plus4;
            id_instr_nxt  = imem_rdata;
            id_pc_nxt     = pc;
            id_pcp4_nxt   = pc_plus4;
            fetch_cnt_nxt = fetch_cnt + CNTW'(1);
        end

        // Every trap or redirect squashes the IF/ID latch
        id_valid_nxt = id_valid;
        if (exc || irq_acc || redirect) begin
            id_valid_nxt = 1'b0;
            id_instr_nxt = IW'(0);
            id_pc_nxt    = AW'(0);
            id_pcp4_nxt  = AW'(0);
        end else if (!stall) begin
            id_valid_nxt = 1'b1;
        end

        pc_nxt = {pc_target[AW-1:2], 2'b00};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= RESET_VEC;
            id_valid  <= 1'b0;
            id_instr  <= IW'(0);
            id_pc     <= AW'(0);
            id_pcp4   <= AW'(0);
            epc       <= AW'(0);
            irq_take  <= 1'b0;
            fetch_cnt <= CNTW'(0);
        end else begin
            pc        <= pc_nxt;
            id_valid  <= id_valid_nxt;
            id_instr  <= id_instr_nxt;
            id_pc     <= id_pc_nxt;
            id_pcp4   <= id_pcp4_nxt;
            epc       <= epc_nxt;
            irq_take  <= irq_acc;
            fetch_cnt <= fetch_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: per-cycle vector table plus a mid-run reset sequence.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        irq;
    logic        exc;
    logic [31:0] exc_pc;
    logic [31:0] pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pcp4;
    logic [31:0] epc;
    logic        irq_take;
    logic [15:0] fetch_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    if_stage dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .irq(irq), .exc(exc), .exc_pc(exc_pc),
        .pc(pc), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc(id_pc), .id_pcp4(id_pcp4), .epc(epc),
        .irq_take(irq_take), .fetch_cnt(fetch_cnt)
    );

    // ROM word equals its address
    assign imem_rdata = imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st, rd;
        logic [31:0] rpc;
        logic        irq, exc;
        logic [31:0] xpc;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_idpc, e_instr, e_epc;
        logic        e_take;
        logic [15:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(logic st, logic rd, logic [31:0] rpc, logic irq_i, logic exc_i,
                                logic [31:0] xpc, logic [31:0] e_pc, logic e_valid,
                                logic [31:0] e_idpc, logic [31:0] e_instr, logic [31:0] e_epc,
                                logic e_take, logic [15:0] e_cnt);
        vec_t v;
        v.st = st; v.rd = rd; v.rpc = rpc; v.irq = irq_i; v.exc = exc_i; v.xpc = xpc;
        v.e_pc = e_pc; v.e_valid = e_valid; v.e_idpc = e_idpc; v.e_instr = e_instr;
        v.e_epc = e_epc; v.e_take = e_take; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic [31:0] e_pc, input logic e_valid,
                           input logic [31:0] e_idpc, input logic [31:0] e_instr,
                           input logic [31:0] e_epc, input logic e_take, input logic [15:0] e_cnt);
        chk("pc", idx, pc, e_pc);
        chk("imem_addr", idx, imem_addr, {1'b0, e_pc[30:0]});
        chk("id_valid", idx, 32'(id_valid), 32'(e_valid));
        chk("id_pc", idx, id_pc, e_idpc);
        chk("id_instr", idx, id_instr, e_instr);
        chk("id_pcp4", idx, id_pcp4, e_valid ? e_idpc + 32'd4 : 32'd0);
        chk("epc", idx, epc, e_epc);
        chk("irq_take", idx, 32'(irq_take), 32'(e_take));
        chk("fetch_cnt", idx, 32'(fetch_cnt), 32'(e_cnt));
    endtask

    vec_t vt[23];

    initial begin
        //          st rd rpc           irq exc xpc    pc            v  id_pc         instr         epc     tk cnt
        vt[0]  = mk(0, 0, 32'h0,        0,  0,  32'h0, 32'h4,        1, 32'h0,        32'h0,        32'h0,   0, 1);
        vt[1]  = mk(0, 0, 32'h0,        0,  0,  32'h0, 32'h8,        1, 32'h4,        32'h4,        32'h0,   0, 2);
        vt[2]  = mk(1, 0, 32'h0,        0,  0,  32'h0, 32'h8,        1, 32'h4,        32'h4,        32'h0,   0, 2);
        vt[3]  = mk(1, 0, 32'h0,        0,  0,  32'h0, 32'h8,        1, 32'h4,        32'h4,        32'h0,   0, 2);
        vt[4]  = mk(0, 0, 32'h0,        0,  0,  32'h0, 32'hC,        1, 32'h8,        32'h8,        32'h0,   0, 3);
        vt[5]  = mk(0, 1, 32'h40,       0,  0,  32'h0, 32'h40,       0, 32'h0,        32'h0,        32'h0,   0, 3);
        vt[6]  = mk(0, 0, 32'h0,        0,  0,  32'h0, 32'h44,       1, 32'h40,       32'h40,       32'h0,   0, 4);
        vt[7]  = mk(1, 1, 32'h10,       0,  0,  32'h0, 32'h10,       0, 32'h0,        32'h0,        32'h0,   0, 4);
        vt[8]  = mk(0, 0, 32'h0,        1,  0,  32'h0, 32'h80000004, 0, 32'h0,        32'h0,        32'h10,  1, 4);
        vt[9]  = mk(0, 0, 32'h0,        1,  0,  32'h0, 32'h80000008, 1, 32'h80000004, 32'h4,        32'h10,  0, 5);
        vt[10] = mk(0, 0, 32'h0,        1,  0,  32'h0, 32'h8000000C, 1, 32'h80000008, 32'h8,        32'h10,  0, 6);
        vt[11] = mk(0, 1, 32'h10,       0,  0,  32'h0, 32'h10,       0, 32'h0,        32'h0,        32'h10,  0, 6);
        vt[12] = mk(0, 0, 32'h0,        0,  0,  32'h0, 32'h14,       1, 32'h10,       32'h10,       32'h10,  0, 7);
        vt[13] = mk(0, 1, 32'h100,      1,  0,  32'h0, 32'h80000004, 0, 32'h0,        32'h0,        32'h100, 1, 7);
        vt[14] = mk(0, 1, 32'h200,      0,  0,  32'h0, 32'h200,      0, 32'h0,        32'h0,        32'h100, 0, 7);
        vt[15] = mk(1, 0, 32'h0,        1,  0,  32'h0, 32'h200,      0, 32'h0,        32'h0,        32'h100, 0, 7);
        vt[16] = mk(0, 0, 32'h0,        1,  1,  32'h20, 32'h80000008, 0, 32'h0,       32'h0,        32'h20,  0, 7);
        vt[17] = mk(0, 0, 32'h0,        0,  0,  32'h0, 32'h8000000C, 1, 32'h80000008, 32'h8,        32'h20,  0, 8);
        vt[18] = mk(0, 1, 32'h43,       0,  0,  32'h0, 32'h40,       0, 32'h0,        32'h0,        32'h20,  0, 8);
        vt[19] = mk(0, 0, 32'h0,        0,  0,  32'h0, 32'h44,       1, 32'h40,       32'h40,       32'h20,  0, 9);
        vt[20] = mk(0, 1, 32'h7FFFFFFC, 0,  0,  32'h0, 32'h7FFFFFFC, 0, 32'h0,        32'h0,        32'h20,  0, 9);
        vt[21] = mk(0, 0, 32'h0,        0,  0,  32'h0, 32'h80000000, 1, 32'h7FFFFFFC, 32'h7FFFFFFC, 32'h20,  0, 10);
        vt[22] = mk(0, 0, 32'h0,        1,  0,  32'h0, 32'h80000004, 1, 32'h80000000, 32'h0,        32'h20,  0, 11);

        reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        irq = 1'b0; exc = 1'b0; exc_pc = '0;

        @(posedge clk); #1;
        chk_all(-1, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
        reset = 1'b1;

        for (int i = 0; i < 23; i++) begin
            stall = vt[i].st; redirect = vt[i].rd; redirect_pc = vt[i].rpc;
            irq = vt[i].irq; exc = vt[i].exc; exc_pc = vt[i].xpc;
            @(posedge clk); #1;
            chk_all(i, vt[i].e_pc, vt[i].e_valid, vt[i].e_idpc, vt[i].e_instr,
                    vt[i].e_epc, vt[i].e_take, vt[i].e_cnt);
        end

        // Asynchronous reset mid-run clears state without a clock edge
        stall = 1'b0; redirect = 1'b0; irq = 1'b0; exc = 1'b0;
        #3 reset = 1'b0;
        #1;
        chk_all(100, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk_all(101, 32'h4, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 16'd1);
        @(posedge clk); #1;
        chk_all(102, 32'h8, 1'b1, 32'h4, 32'h4, 32'h0, 1'b0, 16'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
